// File: rtl/vpu_mul_pipe_pkg.sv
// ---------------------------------------------------------------------------
// vpu_pkg
//  Shared definitions for the pipelined VPU element-wise multiplier.
//  - vmul_mode_e     : operation select carried down the pipe
//  - VMUL_DATA_WIDTH : default signed lane width
//  - sat_clamp       : clamps a wide signed value into a dw-bit signed range
// ---------------------------------------------------------------------------
package vpu_pkg;

  localparam int VMUL_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    VMUL_MODE_MUL  = 2'b00,
    VMUL_MODE_MULS = 2'b01,
    VMUL_MODE_MAC  = 2'b10,
    VMUL_MODE_RSVD = 2'b11
  } vmul_mode_e;

  // The caller sign-extends into 64 bits so one function serves any lane
  // width up to 63 bits; a changed return value means the lane saturated.
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v,
                                                   input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) begin
      return hi;
    end
    if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/vpu_mul_pipe_if.sv
// ---------------------------------------------------------------------------
// vpu_mul_pipe_if
//  Valid/ready operand and result streams of vpu_mul_pipe.
//  master : producer of operands / consumer of results (decode side)
//  slave  : the multiplier pipeline itself
//  in_*   : operand vector, mode and shift, accepted on in_valid && in_ready
//  out_*  : result vector, per-lane saturation flags and reserved-mode error,
//           transferred on out_valid && out_ready
// ---------------------------------------------------------------------------
interface vpu_mul_pipe_if #(
  parameter int LANES      = 8,
  parameter int DATA_WIDTH = 16,
  parameter int SHIFT_W    = 5
);

  logic                          in_valid;
  logic                          in_ready;
  logic [1:0]                    in_mode;
  logic [SHIFT_W-1:0]            in_shift;
  logic [LANES*DATA_WIDTH-1:0]   in_a;
  logic [LANES*DATA_WIDTH-1:0]   in_b;
  logic [LANES*DATA_WIDTH-1:0]   in_c;
  logic                          out_valid;
  logic                          out_ready;
  logic [LANES*DATA_WIDTH-1:0]   out_data;
  logic [LANES-1:0]              out_sat;
  logic                          out_err;

  modport master (
    output in_valid, in_mode, in_shift, in_a, in_b, in_c, out_ready,
    input  in_ready, out_valid, out_data, out_sat, out_err
  );

  modport slave (
    input  in_valid, in_mode, in_shift, in_a, in_b, in_c, out_ready,
    output in_ready, out_valid, out_data, out_sat, out_err
  );

endinterface

// File: rtl/vpu_mul_pipe_lane.sv
// ---------------------------------------------------------------------------
// vpu_mul_lane
//  One lane of the multiplier datapath, stages S2 and S3.
//  S2 : full 2*DW signed product of the S1 operands, addend carried along
//  S3 : round-half-up, arithmetic right shift, optional addend, saturation
//  Ports:
//    clk, rst_n   clock / async active-low reset
//    load_s2      capture product (pipe advancing with a valid S1 vector)
//    load_s3      capture result  (pipe advancing with a valid S2 vector)
//    a, b, c      S1 operands for this lane (b already broadcast for MULS)
//    shift_s2     clamped shift amount belonging to the S2 vector
//    mac_s2       S2 vector is a multiply-accumulate
//    res, sat     registered lane result and saturation flag
// ---------------------------------------------------------------------------
module vpu_mul_lane
  import vpu_pkg::*;
#(
  parameter int DATA_WIDTH = VMUL_DATA_WIDTH,
  parameter int SHIFT_W    = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load_s2,
  input  logic                         load_s3,
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  input  logic signed [DATA_WIDTH-1:0] c,
  input  logic [SHIFT_W-1:0]           shift_s2,
  input  logic                         mac_s2,
  output logic signed [DATA_WIDTH-1:0] res,
  output logic                         sat
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int RW = PW + 1;
  localparam int SW = PW + 2;

  logic signed [PW-1:0]         prod_q;
  logic signed [DATA_WIDTH-1:0] c_q;
  logic signed [RW-1:0]         rnd;
  logic signed [RW-1:0]         rounded;
  logic signed [RW-1:0]         shifted;
  logic signed [SW-1:0]         sum;
  logic signed [63:0]           wide;
  logic signed [63:0]           clamped;

  // S2: operands are sign-extended first so the product is exact
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
      c_q    <= '0;
    end else if (load_s2) begin
      prod_q <= $signed({{DATA_WIDTH{a[DATA_WIDTH-1]}}, a}) *
                $signed({{DATA_WIDTH{b[DATA_WIDTH-1]}}, b});
      c_q    <= c;
    end
  end

  // S3 arithmetic: one extra bit keeps the rounding increment from
  // overflowing, two extra bits keep the addend from overflowing
  always_comb begin
    rnd = '0;
    if (shift_s2 != '0) begin
      rnd = {{(RW-1){1'b0}}, 1'b1} << (shift_s2 - SHIFT_W'(1));
    end
    rounded = $signed({prod_q[PW-1], prod_q}) + rnd;
    shifted = rounded >>> shift_s2;
    sum     = {shifted[RW-1], shifted};
    if (mac_s2) begin
      sum = sum + $signed({{(SW-DATA_WIDTH){c_q[DATA_WIDTH-1]}}, c_q});
    end
    wide    = {{(64-SW){sum[SW-1]}}, sum};
    clamped = sat_clamp(wide, DATA_WIDTH);
  end

  // S3 register: result only moves when a valid vector advances into it,
  // so it stays stable while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res <= '0;
      sat <= 1'b0;
    end else if (load_s3) begin
      res <= clamped[DATA_WIDTH-1:0];
      sat <= (clamped != wide);
    end
  end

endmodule

// File: rtl/vpu_mul_pipe.sv
// ---------------------------------------------------------------------------
// vpu_mul_pipe
//  Three-stage pipelined element-wise multiplier with rounding right shift,
//  signed saturation, scalar broadcast (MULS) and multiply-accumulate (MAC).
//  Ports:
//    clk, rst_n   clock / async active-low reset
//    bus          vpu_mul_pipe_if.slave operand and result streams
//    clear_stats  synchronous clear of sat_count (wins over counting)
//    sat_count    saturated lanes transferred since reset/clear, sticky max
//  The top owns stall control, the MULS broadcast mux, the S1 registers,
//  the mode/shift sidebands and the saturation counter; the per-lane
//  arithmetic lives in vpu_mul_lane.
// ---------------------------------------------------------------------------
module vpu_mul_pipe
  import vpu_pkg::*;
#(
  parameter int LANES      = 8,
  parameter int DATA_WIDTH = VMUL_DATA_WIDTH,
  parameter int SHIFT_W    = 5,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  vpu_mul_pipe_if.slave    bus,
  input  logic             clear_stats,
  output logic [CNT_W-1:0] sat_count
);

  localparam int MAX_SHIFT = 2 * DATA_WIDTH - 1;
  localparam int POP_W     = $clog2(LANES + 1);
  localparam int VW        = LANES * DATA_WIDTH;

  logic               advance;
  logic [SHIFT_W-1:0] shift_cl;
  logic [VW-1:0]      b_sel;

  logic               v1;
  vmul_mode_e         mode1;
  logic [SHIFT_W-1:0] shift1;
  logic [VW-1:0]      a1;
  logic [VW-1:0]      b1;
  logic [VW-1:0]      c1;

  logic               v2;
  vmul_mode_e         mode2;
  logic [SHIFT_W-1:0] shift2;
  logic               mac2;

  logic [VW-1:0]      lane_data;
  logic [LANES-1:0]   lane_sat;
  logic [POP_W-1:0]   sat_pop;
  logic [CNT_W:0]     cnt_sum;

  // The whole pipe moves as one unit: it advances whenever the output
  // register is empty or being drained this cycle
  assign advance      = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = advance;
  assign mac2         = (mode2 == VMUL_MODE_MAC);

  // Shift clamp and MULS broadcast are resolved before S1 so later
  // stages never need to know about them
  always_comb begin
    shift_cl = bus.in_shift;
    if (int'(bus.in_shift) > MAX_SHIFT) begin
      shift_cl = SHIFT_W'(MAX_SHIFT);
    end
    b_sel = bus.in_b;
    if (bus.in_mode == VMUL_MODE_MULS) begin
      for (int i = 0; i < LANES; i++) begin
        b_sel[i*DATA_WIDTH +: DATA_WIDTH] = bus.in_b[DATA_WIDTH-1:0];
      end
    end
  end

  // S1: capture operands on accept; a bubble enters when in_valid is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1     <= 1'b0;
      mode1  <= VMUL_MODE_MUL;
      shift1 <= '0;
      a1     <= '0;
      b1     <= '0;
      c1     <= '0;
    end else if (advance) begin
      v1 <= bus.in_valid;
      if (bus.in_valid) begin
        mode1  <= vmul_mode_e'(bus.in_mode);
        shift1 <= shift_cl;
        a1     <= bus.in_a;
        b1     <= b_sel;
        c1     <= bus.in_c;
      end
    end
  end

  // S2 sidebands travelling alongside the lane products
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2     <= 1'b0;
      mode2  <= VMUL_MODE_MUL;
      shift2 <= '0;
    end else if (advance) begin
      v2 <= v1;
      if (v1) begin
        mode2  <= mode1;
        shift2 <= shift1;
      end
    end
  end

  // S3 control: valid and the reserved-mode flag for the output vector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_err   <= 1'b0;
    end else if (advance) begin
      bus.out_valid <= v2;
      if (v2) begin
        bus.out_err <= (mode2 == VMUL_MODE_RSVD);
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    vpu_mul_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .SHIFT_W    (SHIFT_W)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_s2  (advance && v1),
      .load_s3  (advance && v2),
      .a        (a1[g*DATA_WIDTH +: DATA_WIDTH]),
      .b        (b1[g*DATA_WIDTH +: DATA_WIDTH]),
      .c        (c1[g*DATA_WIDTH +: DATA_WIDTH]),
      .shift_s2 (shift2),
      .mac_s2   (mac2),
      .res      (lane_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .sat      (lane_sat[g])
    );
  end

  assign bus.out_data = lane_data;
  assign bus.out_sat  = lane_sat;

  // Number of saturated lanes in the vector currently on the output
  always_comb begin
    sat_pop = '0;
    for (int i = 0; i < LANES; i++) begin
      sat_pop = sat_pop + POP_W'(lane_sat[i]);
    end
    cnt_sum = {1'b0, sat_count} + (CNT_W+1)'(sat_pop);
  end

  // Counts only on real transfers so a stalled vector is counted once;
  // the carry-out bit detects overflow and pins the count at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if (clear_stats) begin
      sat_count <= '0;
    end else if (bus.out_valid && bus.out_ready) begin
      sat_count <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_vpu_mul_pipe.sv
// ---------------------------------------------------------------------------
// tb_vpu_mul_pipe
//  Directed scenarios plus a randomized backpressured stream for
//  vpu_mul_pipe, checked against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_vpu_mul_pipe;

  localparam int LANES = 8;
  localparam int DW    = 16;
  localparam int SW    = 5;
  localparam int CW    = 16;
  localparam int VW    = LANES * DW;

  typedef struct packed {
    logic [VW-1:0]    d;
    logic [LANES-1:0] s;
    logic             e;
  } res_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear_stats = 1'b0;
  logic [CW-1:0] sat_count;

  vpu_mul_pipe_if #(.LANES(LANES), .DATA_WIDTH(DW), .SHIFT_W(SW)) bus ();

  vpu_mul_pipe #(
    .LANES      (LANES),
    .DATA_WIDTH (DW),
    .SHIFT_W    (SW),
    .CNT_W      (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .clear_stats (clear_stats),
    .sat_count   (sat_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int exp_cnt = 0;

  int         a_v [LANES];
  int         b_v [LANES];
  int         c_v [LANES];
  int         r_data [LANES];
  logic [7:0] r_sat;
  logic       r_err;
  int         r_lat;

  res_t exp_q [$];

  // Reference: p = a*b, round-half-up shift, optional addend, clamp
  function automatic void model_lane(input longint a, input longint b, input longint c,
                                     input int mode, input int shift,
                                     output longint res, output bit sat);
    longint p, r, sum, hi, lo;
    int s;
    p = a * b;
    s = (shift > 2*DW-1) ? 2*DW-1 : shift;
    r = p;
    if (s > 0) r = (p + (longint'(1) << (s - 1))) >>> s;
    sum = (mode == 2) ? r + c : r;
    hi = (longint'(1) << (DW - 1)) - 1;
    lo = -(longint'(1) << (DW - 1));
    res = sum;
    sat = 1'b0;
    if (sum > hi) begin res = hi; sat = 1'b1; end
    else if (sum < lo) begin res = lo; sat = 1'b1; end
  endfunction

  function automatic res_t model_vec(input int mode, input int shift,
                                     input logic [VW-1:0] a, input logic [VW-1:0] b,
                                     input logic [VW-1:0] c);
    res_t r;
    longint av, bv, cv, rv;
    bit s;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      av = longint'($signed(a[i*DW +: DW]));
      bv = (mode == 1) ? longint'($signed(b[DW-1:0])) : longint'($signed(b[i*DW +: DW]));
      cv = longint'($signed(c[i*DW +: DW]));
      model_lane(av, bv, cv, mode, shift, rv, s);
      r.d[i*DW +: DW] = rv[DW-1:0];
      r.s[i] = s;
    end
    r.e = (mode == 3);
    return r;
  endfunction

  // Sends one vector from a drained pipe and collects its result with
  // out_ready held high; r_lat counts edges from accept to out_valid
  task automatic run_vec(input logic [1:0] mode, input logic [4:0] shift, input bit do_clear);
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_mode   = mode;
    bus.in_shift  = shift;
    for (int i = 0; i < LANES; i++) begin
      bus.in_a[i*DW +: DW] = 16'(a_v[i]);
      bus.in_b[i*DW +: DW] = 16'(b_v[i]);
      bus.in_c[i*DW +: DW] = 16'(c_v[i]);
    end
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    r_lat = 1;
    while (!bus.out_valid && r_lat < 20) begin
      @(posedge clk);
      #1;
      r_lat++;
    end
    if (!bus.out_valid) r_lat = -1;
    for (int i = 0; i < LANES; i++) r_data[i] = int'($signed(bus.out_data[i*DW +: DW]));
    r_sat = bus.out_sat;
    r_err = bus.out_err;
    if (do_clear) clear_stats = 1'b1;
    @(posedge clk);
    #1;
    clear_stats = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_mode = 2'b00;
    bus.in_shift = '0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_c = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.out_data !== '0) begin bad++; $display("[TB] FAIL reset_out_data: got %h want 0", bus.out_data); end
    total++; if (bus.out_sat !== '0) begin bad++; $display("[TB] FAIL reset_out_sat: got %b want 0", bus.out_sat); end
    total++; if (bus.out_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_err: got %b want 0", bus.out_err); end
    total++; if (sat_count !== '0) begin bad++; $display("[TB] FAIL reset_sat_count: got %0d want 0", sat_count); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    exp_cnt = 0;
  endtask

  task automatic test_mul();
    int exp_d [LANES] = '{2, 6, 12, 20, 30, 42, 56, 72};
    for (int i = 0; i < LANES; i++) begin a_v[i] = i + 2; b_v[i] = i + 1; c_v[i] = 0; end
    run_vec(2'b00, 5'd0, 1'b0);
    total++; if (r_lat !== 3) begin bad++; $display("[TB] FAIL mul_latency: got %0d want 3", r_lat); end
    for (int i = 0; i < LANES; i++) begin
      total++; if (r_data[i] !== exp_d[i]) begin bad++; $display("[TB] FAIL mul_lane%0d: got %0d want %0d", i, r_data[i], exp_d[i]); end
    end
    total++; if (r_sat !== 8'h00) begin bad++; $display("[TB] FAIL mul_sat: got %b want 0", r_sat); end
    total++; if (r_err !== 1'b0) begin bad++; $display("[TB] FAIL mul_err: got %b want 0", r_err); end
  endtask

  task automatic test_signed_mul();
    int av [LANES] = '{-3, 4, -5, 6, -7, 8, -9, 10};
    int exp_d [LANES] = '{-6, -8, -10, -12, -14, -16, -18, -20};
    for (int i = 0; i < LANES; i++) begin a_v[i] = av[i]; b_v[i] = (i % 2 == 0) ? 2 : -2; c_v[i] = 0; end
    run_vec(2'b00, 5'd0, 1'b0);
    for (int i = 0; i < LANES; i++) begin
      total++; if (r_data[i] !== exp_d[i]) begin bad++; $display("[TB] FAIL smul_lane%0d: got %0d want %0d", i, r_data[i], exp_d[i]); end
    end
  endtask

  task automatic test_muls_round();
    for (int i = 0; i < LANES; i++) begin a_v[i] = 100 * (i + 1); b_v[i] = (i == 0) ? 3 : 99; c_v[i] = 0; end
    run_vec(2'b01, 5'd1, 1'b0);
    for (int i = 0; i < LANES; i++) begin
      total++; if (r_data[i] !== 150 * (i + 1)) begin bad++; $display("[TB] FAIL muls_lane%0d: got %0d want %0d", i, r_data[i], 150 * (i + 1)); end
    end
    for (int i = 0; i < LANES; i++) begin a_v[i] = 0; b_v[i] = 0; c_v[i] = 0; end
    a_v[0] = 3;  b_v[0] = 1;
    a_v[1] = -3; b_v[1] = 1;
    run_vec(2'b00, 5'd1, 1'b0);
    total++; if (r_data[0] !== 2) begin bad++; $display("[TB] FAIL round_pos: got %0d want 2", r_data[0]); end
    total++; if (r_data[1] !== -1) begin bad++; $display("[TB] FAIL round_neg: got %0d want -1", r_data[1]); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < LANES; i++) begin a_v[i] = 0; b_v[i] = 0; c_v[i] = 0; end
    a_v[0] = 300;  b_v[0] = 200;
    a_v[1] = -300; b_v[1] = 200;
    run_vec(2'b00, 5'd0, 1'b0);
    exp_cnt += 2;
    total++; if (r_data[0] !== 32767) begin bad++; $display("[TB] FAIL sat_pos: got %0d want 32767", r_data[0]); end
    total++; if (r_data[1] !== -32768) begin bad++; $display("[TB] FAIL sat_neg: got %0d want -32768", r_data[1]); end
    total++; if (r_sat !== 8'b0000_0011) begin bad++; $display("[TB] FAIL sat_flags: got %b want 00000011", r_sat); end
    total++; if (int'(sat_count) !== exp_cnt) begin bad++; $display("[TB] FAIL sat_count_add: got %0d want %0d", sat_count, exp_cnt); end
    run_vec(2'b00, 5'd0, 1'b1);
    exp_cnt = 0;
    total++; if (int'(sat_count) !== exp_cnt) begin bad++; $display("[TB] FAIL sat_count_clear: got %0d want %0d", sat_count, exp_cnt); end
  endtask

  task automatic test_mac_reserved();
    for (int i = 0; i < LANES; i++) begin a_v[i] = 0; b_v[i] = 0; c_v[i] = 0; end
    a_v[0] = 5; b_v[0] = 6; c_v[0] = -10;
    a_v[1] = 1; b_v[1] = 1; c_v[1] = 32767;
    run_vec(2'b10, 5'd0, 1'b0);
    exp_cnt += 1;
    total++; if (r_data[0] !== 20) begin bad++; $display("[TB] FAIL mac_basic: got %0d want 20", r_data[0]); end
    total++; if (r_data[1] !== 32767) begin bad++; $display("[TB] FAIL mac_sat: got %0d want 32767", r_data[1]); end
    total++; if (r_sat !== 8'b0000_0010) begin bad++; $display("[TB] FAIL mac_flags: got %b want 00000010", r_sat); end
    total++; if (int'(sat_count) !== exp_cnt) begin bad++; $display("[TB] FAIL mac_count: got %0d want %0d", sat_count, exp_cnt); end
    for (int i = 0; i < LANES; i++) begin a_v[i] = i + 2; b_v[i] = i + 1; c_v[i] = 1000; end
    run_vec(2'b11, 5'd0, 1'b0);
    for (int i = 0; i < LANES; i++) begin
      total++; if (r_data[i] !== (i + 2) * (i + 1)) begin bad++; $display("[TB] FAIL rsvd_lane%0d: got %0d want %0d", i, r_data[i], (i + 2) * (i + 1)); end
    end
    total++; if (r_err !== 1'b1) begin bad++; $display("[TB] FAIL rsvd_err: got %b want 1", r_err); end
    run_vec(2'b00, 5'd0, 1'b0);
    total++; if (r_err !== 1'b0) begin bad++; $display("[TB] FAIL rsvd_err_clears: got %b want 0", r_err); end
  endtask

  task automatic test_stream();
    int sent = 0;
    int got = 0;
    int cyc = 0;
    int stall = 0;
    bit pending = 0;
    bit held = 0;
    bit tin, tout;
    logic [VW-1:0] hd;
    logic [LANES-1:0] hs;
    logic he;
    logic [1:0] m;
    logic [4:0] sh;
    logic [VW-1:0] av, bv, cv;
    res_t e;
    exp_q.delete();
    while (got < 16 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 8) stall = 4;
      if (stall > 0) begin
        bus.out_ready = 1'b0;
        stall--;
      end else begin
        bus.out_ready = ($urandom_range(0, 3) != 0);
      end
      if (!pending && sent < 16 && $urandom_range(0, 4) != 0) begin
        m  = 2'($urandom_range(0, 3));
        sh = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 4)) : 5'($urandom_range(0, 31));
        for (int i = 0; i < LANES; i++) begin
          av[i*DW +: DW] = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 400) - 200);
          bv[i*DW +: DW] = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 400) - 200);
          cv[i*DW +: DW] = 16'($urandom);
        end
        bus.in_mode  = m;
        bus.in_shift = sh;
        bus.in_a     = av;
        bus.in_b     = bv;
        bus.in_c     = cv;
        bus.in_valid = 1'b1;
        pending = 1;
      end else if (!pending) begin
        bus.in_valid = 1'b0;
      end
      #1;
      tin  = bus.in_valid && bus.in_ready;
      tout = bus.out_valid && bus.out_ready;
      if (held) begin
        total++;
        if (!bus.out_valid || bus.out_data !== hd || bus.out_sat !== hs || bus.out_err !== he) begin
          bad++;
          $display("[TB] FAIL stream_hold: got v=%b d=%h want v=1 d=%h", bus.out_valid, bus.out_data, hd);
        end
      end
      held = bus.out_valid && !bus.out_ready;
      hd = bus.out_data;
      hs = bus.out_sat;
      he = bus.out_err;
      if (tout) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL stream_extra: got unexpected output %h want none", bus.out_data);
        end else begin
          e = exp_q.pop_front();
          total++; if (bus.out_data !== e.d) begin bad++; $display("[TB] FAIL stream_data%0d: got %h want %h", got, bus.out_data, e.d); end
          total++; if (bus.out_sat !== e.s) begin bad++; $display("[TB] FAIL stream_sat%0d: got %b want %b", got, bus.out_sat, e.s); end
          total++; if (bus.out_err !== e.e) begin bad++; $display("[TB] FAIL stream_err%0d: got %b want %b", got, bus.out_err, e.e); end
          exp_cnt = exp_cnt + $countones(e.s);
          if (exp_cnt > 65535) exp_cnt = 65535;
        end
        got++;
      end
      if (tin) begin
        exp_q.push_back(model_vec(int'(m), int'(sh), av, bv, cv));
        sent++;
      end
      @(posedge clk);
      if (tin) pending = 0;
    end
    bus.in_valid = 1'b0;
    total++; if (got !== 16) begin bad++; $display("[TB] FAIL stream_count: got %0d want 16", got); end
    @(negedge clk);
    total++; if (int'(sat_count) !== exp_cnt) begin bad++; $display("[TB] FAIL stream_sat_count: got %0d want %0d", sat_count, exp_cnt); end
  endtask

  task automatic test_reset_midstream();
    int stale = 0;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_mode = 2'b00;
    bus.in_shift = '0;
    bus.in_a = {VW/16{16'h0101}};
    bus.in_b = {VW/16{16'h0003}};
    bus.in_c = '0;
    bus.in_valid = 1'b1;
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL midreset_out_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.out_data !== '0) begin bad++; $display("[TB] FAIL midreset_out_data: got %h want 0", bus.out_data); end
    total++; if (int'(sat_count) !== exp_cnt) begin bad++; $display("[TB] FAIL midreset_sat_count: got %0d want %0d", sat_count, exp_cnt); end
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) stale++;
    end
    total++; if (stale !== 0) begin bad++; $display("[TB] FAIL midreset_stale: got %0d outputs want 0", stale); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL midreset_in_ready: got %b want 1", bus.in_ready); end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_mul();
    test_signed_mul();
    test_muls_round();
    test_saturation();
    test_mac_reserved();
    test_stream();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
